controle_mapa: RTL and testbench
================================

CONTROLE_MAPA -- requirements
Module: controle_mapa

Interface
REQ-001 Parameter tamanhoDistancia, default 8: width in bits of every position and distance field.
REQ-002 Parameter ProfundidadeFila, default 4: FIFO depth in samples, a power of two, at least 2.
REQ-003 Parameter TempoLimite, default 1023: watchdog limit in cycles for one mapping operation, at least 2.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 amostraValida  in  1  producer offers a sample this cycle.
REQ-007 amostraPronta  out  1  controller can accept a sample (FIFO not full).
REQ-008 posX, posY  in  tamanhoDistancia  sample position.
REQ-009 direcao  in  1  sample heading: 1 = horizontal, 0 = vertical.
REQ-010 distDireita, distEsquerda  in  tamanhoDistancia  sample side distances.
REQ-011 mapaLivre  in  1  mapping unit idle/finished flag; 1 = free.
REQ-012 novoDado  out  1  one-cycle start pulse to the mapping unit.
REQ-013 mapaX, mapaY, mapaDistDireita, mapaDistEsquerda  out  tamanhoDistancia  registered operands to the mapping unit.
REQ-014 mapaDirecao  out  1  registered heading operand.
REQ-015 ocupado  out  1  an operation is in flight.
REQ-016 nivelFila  out  $clog2(ProfundidadeFila)+1  current FIFO occupancy.
REQ-017 descartadas  out  8  count of refused samples, saturating.
REQ-018 erroTimeout  out  1  sticky watchdog error flag.

Function
REQ-019 A sample SHALL be pushed in any cycle where amostraValida and amostraPronta are both 1.
REQ-020 amostraPronta SHALL be 1 exactly when nivelFila < ProfundidadeFila; a pop in the same cycle SHALL NOT make a full FIFO accept a push.
REQ-021 amostraValida with amostraPronta = 0 SHALL increment descartadas, saturating at 255.
REQ-022 Samples SHALL be issued in strict FIFO order; pointers wrap modulo ProfundidadeFila.
REQ-023 Simultaneous push and pop SHALL leave nivelFila unchanged.
REQ-024 FSM states SHALL be OCIOSO, AGUARDA_INICIO and AGUARDA_FIM.
REQ-025 OCIOSO: if the FIFO is non-empty and mapaLivre = 1, the head SHALL be popped into the mapa* registers and novoDado SHALL pulse for exactly one cycle, simultaneously with the operands; next state AGUARDA_INICIO.
REQ-026 A sample pushed at edge t into an empty FIFO, with mapaLivre = 1, SHALL produce novoDado = 1 in the cycle after edge t+1.
REQ-027 AGUARDA_INICIO: on mapaLivre = 0 the FSM SHALL go to AGUARDA_FIM.
REQ-028 AGUARDA_FIM: on mapaLivre = 1 the FSM SHALL go to OCIOSO; no new issue SHALL occur in that same cycle.
REQ-029 The mapa* outputs SHALL hold constant from the issue until the FSM returns to OCIOSO.
REQ-030 ocupado SHALL be 1 in AGUARDA_INICIO and AGUARDA_FIM, and 0 in OCIOSO.
REQ-031 Watchdog behaviour: a cycle counter SHALL clear on issue and increment each cycle in the two wait states; on reaching TempoLimite the FSM SHALL set erroTimeout and return to OCIOSO. The sample is treated as consumed.
REQ-032 erroTimeout SHALL clear only on reset; issuing SHALL continue while it is set.

Reset
REQ-033 Reset SHALL be asynchronous and active-high, effective mid-operation, and SHALL discard FIFO contents and any in-flight operation.
REQ-034 Reset values: FSM = OCIOSO; novoDado = 0; ocupado = 0; nivelFila = 0; amostraPronta = 1; descartadas = 0; erroTimeout = 0; all mapa* outputs = 0.

Verification
REQ-035 Single sample: push (posX=5, posY=7, direcao=1, distDireita=3, distEsquerda=2) with mapaLivre = 1 -> one novoDado pulse on the second edge carrying those values; mapaLivre held 0 for 10 cycles then 1 -> ocupado falls, nivelFila = 0.
REQ-036 Overflow: push 6 samples back-to-back with mapaLivre = 0 and depth 4 -> amostraPronta = 0 after the 4th push, descartadas = 2, nivelFila = 4.
REQ-037 Ordering: queue samples A, B, C; answer each issue with 3 busy cycles -> issue order A, B, C, and operands stable during each busy window.
REQ-038 Timeout: issue with mapaLivre stuck at 1 and TempoLimite = 16 -> erroTimeout = 1 at the 16th wait cycle, FSM back to OCIOSO, next queued sample issued.
REQ-039 Reset mid-operation: assert reset in AGUARDA_FIM with 2 samples queued -> all REQ-034 values take effect immediately, with no novoDado after release until a new push.
REQ-040 Saturation: 300 refused samples -> descartadas = 255.

Source files
------------

// File: rtl/controle_mapa_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : controle_mapa_if                                             |
// | Brief   : sample producer / mapping unit bus for controle_mapa         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface controle_mapa_if #(
  parameter int tamanhoDistancia = 8,
  parameter int ProfundidadeFila = 4
);
  localparam int c_larguraNivel = $clog2(ProfundidadeFila) + 1;

  logic                        amostraValida;
  logic                        amostraPronta;
  logic [tamanhoDistancia-1:0] posX;
  logic [tamanhoDistancia-1:0] posY;
  logic                        direcao;
  logic [tamanhoDistancia-1:0] distDireita;
  logic [tamanhoDistancia-1:0] distEsquerda;
  logic                        mapaLivre;
  logic                        novoDado;
  logic [tamanhoDistancia-1:0] mapaX;
  logic [tamanhoDistancia-1:0] mapaY;
  logic [tamanhoDistancia-1:0] mapaDistDireita;
  logic [tamanhoDistancia-1:0] mapaDistEsquerda;
  logic                        mapaDirecao;
  logic                        ocupado;
  logic [c_larguraNivel-1:0]   nivelFila;
  logic [7:0]                  descartadas;
  logic                        erroTimeout;

  modport master (
    output amostraValida, posX, posY, direcao, distDireita, distEsquerda, mapaLivre,
    input  amostraPronta, novoDado, mapaX, mapaY, mapaDistDireita, mapaDistEsquerda,
           mapaDirecao, ocupado, nivelFila, descartadas, erroTimeout
  );

  modport slave (
    input  amostraValida, posX, posY, direcao, distDireita, distEsquerda, mapaLivre,
    output amostraPronta, novoDado, mapaX, mapaY, mapaDistDireita, mapaDistEsquerda,
           mapaDirecao, ocupado, nivelFila, descartadas, erroTimeout
  );
endinterface
`default_nettype wire

// File: rtl/controle_mapa.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : controle_mapa                                                |
// | Brief   : sample FIFO feeding a mapping unit, with issue FSM, watchdog |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module controle_mapa #(
  parameter int tamanhoDistancia = 8,
  parameter int ProfundidadeFila = 4,
  parameter int TempoLimite      = 1023
) (
  input  wire logic      clock,
  input  wire logic      reset,
  controle_mapa_if.slave bus
);
  localparam int c_larguraPtr     = $clog2(ProfundidadeFila);
  localparam int c_larguraNivel   = c_larguraPtr + 1;
  localparam int c_larguraAmostra = 4 * tamanhoDistancia + 1;
  localparam int c_larguraCont    = $clog2(TempoLimite + 1);
  localparam logic [c_larguraNivel-1:0] c_profundidade = c_larguraNivel'(ProfundidadeFila);
  localparam logic [c_larguraCont-1:0]  c_limite       = c_larguraCont'(TempoLimite - 1);

  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,
    AGUARDA_INICIO = 2'd1,
    AGUARDA_FIM    = 2'd2
  } estado_t;

  estado_t                     r_estado, w_proximo;
  logic [c_larguraAmostra-1:0] r_fila [ProfundidadeFila];
  logic [c_larguraPtr-1:0]     r_ptrEscrita, r_ptrLeitura;
  logic [c_larguraNivel-1:0]   r_nivel;
  logic [7:0]                  r_descartadas;
  logic [c_larguraCont-1:0]    r_contador;
  logic                        r_novoDado, r_erro;
  logic [c_larguraAmostra-1:0] r_operandos;
  logic [c_larguraAmostra-1:0] w_amostra, w_cabeca;
  logic                        w_pronta, w_push, w_emite, w_timeout;

  assign w_pronta  = (r_nivel < c_profundidade);
  assign w_push    = bus.amostraValida & w_pronta;
  assign w_amostra = {bus.posX, bus.posY, bus.direcao, bus.distDireita, bus.distEsquerda};
  assign w_cabeca  = r_fila[r_ptrLeitura];

  // Storage needs no reset: occupancy and pointers alone define validity.
  always_ff @(posedge clock) begin
    if (w_push) r_fila[r_ptrEscrita] <= w_amostra;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptrEscrita  <= '0;
      r_ptrLeitura  <= '0;
      r_nivel       <= '0;
      r_descartadas <= '0;
    end else begin
      if (w_push) r_ptrEscrita <= r_ptrEscrita + 1'b1;
      if (w_emite) r_ptrLeitura <= r_ptrLeitura + 1'b1;
      if (w_push && !w_emite) r_nivel <= r_nivel + 1'b1;
      else if (!w_push && w_emite) r_nivel <= r_nivel - 1'b1;
      if (bus.amostraValida && !w_pronta && r_descartadas != 8'hFF)
        r_descartadas <= r_descartadas + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_proximo;
  end

  // Watchdog takes priority over the normal handshake in both wait states.
  always_comb begin
    w_proximo = r_estado;
    w_emite   = 1'b0;
    w_timeout = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (r_nivel != '0 && bus.mapaLivre) begin
          w_emite   = 1'b1;
          w_proximo = AGUARDA_INICIO;
        end
      end
      AGUARDA_INICIO: begin
        if (r_contador == c_limite) begin
          w_timeout = 1'b1;
          w_proximo = OCIOSO;
        end else if (!bus.mapaLivre) begin
          w_proximo = AGUARDA_FIM;
        end
      end
      AGUARDA_FIM: begin
        if (r_contador == c_limite) begin
          w_timeout = 1'b1;
          w_proximo = OCIOSO;
        end else if (bus.mapaLivre) begin
          w_proximo = OCIOSO;
        end
      end
      default: w_proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contador  <= '0;
      r_novoDado  <= 1'b0;
      r_erro      <= 1'b0;
      r_operandos <= '0;
    end else begin
      r_novoDado <= w_emite;
      if (w_emite) begin
        r_contador  <= '0;
        r_operandos <= w_cabeca;
      end else if (r_estado != OCIOSO) begin
        r_contador <= r_contador + 1'b1;
      end
      if (w_timeout) r_erro <= 1'b1;
    end
  end

  assign bus.amostraPronta    = w_pronta;
  assign bus.novoDado         = r_novoDado;
  assign bus.ocupado          = (r_estado != OCIOSO);
  assign bus.nivelFila        = r_nivel;
  assign bus.descartadas      = r_descartadas;
  assign bus.erroTimeout      = r_erro;
  assign {bus.mapaX, bus.mapaY, bus.mapaDirecao, bus.mapaDistDireita, bus.mapaDistEsquerda} = r_operandos;
endmodule
`default_nettype wire

// File: tb/tb_controle_mapa.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_controle_mapa                                             |
// | Brief   : directed self-checking bench for controle_mapa               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_controle_mapa;
  localparam int c_w = 8;
  localparam int c_p = 4;
  localparam int c_t = 16;

  logic clock = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFalhas = 0;

  controle_mapa_if #(.tamanhoDistancia(c_w), .ProfundidadeFila(c_p)) bus ();

  controle_mapa #(
    .tamanhoDistancia(c_w),
    .ProfundidadeFila(c_p),
    .TempoLimite     (c_t)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    nChecks++;
    if (obs !== esp) begin
      nFalhas++;
      $display("FAIL %s: observado=%0d esperado=%0d", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic amostra(input logic v, input logic [7:0] x, input logic [7:0] y,
                         input logic d, input logic [7:0] dd, input logic [7:0] de);
    bus.amostraValida = v;
    bus.posX          = x;
    bus.posY          = y;
    bus.direcao       = d;
    bus.distDireita   = dd;
    bus.distEsquerda  = de;
  endtask

  task automatic confereReset(input string tag);
    verifica({tag, "_novoDado"}, bus.novoDado, 0);
    verifica({tag, "_ocupado"}, bus.ocupado, 0);
    verifica({tag, "_nivel"}, bus.nivelFila, 0);
    verifica({tag, "_pronta"}, bus.amostraPronta, 1);
    verifica({tag, "_descartadas"}, bus.descartadas, 0);
    verifica({tag, "_erro"}, bus.erroTimeout, 0);
    verifica({tag, "_operandos"}, {bus.mapaX, bus.mapaY, bus.mapaDistDireita, bus.mapaDistEsquerda}, 0);
    verifica({tag, "_direcao"}, bus.mapaDirecao, 0);
  endtask

  task automatic esperaEmissao(input string tag);
    int n = 0;
    while (bus.novoDado !== 1'b1 && n < 8) begin
      ciclo();
      n++;
    end
    verifica({tag, "_emissao"}, bus.novoDado, 1);
  endtask

  logic [7:0] expX [3] = '{8'd10, 8'd11, 8'd12};
  logic [7:0] expY [3] = '{8'd20, 8'd21, 8'd22};
  logic [7:0] expD [3] = '{8'd1, 8'd2, 8'd3};
  logic [7:0] expE [3] = '{8'd9, 8'd8, 8'd7};
  logic       expH [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    reset         = 1'b1;
    bus.mapaLivre = 1'b1;
    amostra(0, 0, 0, 0, 0, 0);
    repeat (2) ciclo();
    confereReset("reset");
    reset = 1'b0;
    ciclo();

    // Single sample: issue on the second edge after the push
    amostra(1, 5, 7, 1, 3, 2);
    ciclo();
    bus.amostraValida = 1'b0;
    verifica("s1_nivel_push", bus.nivelFila, 1);
    verifica("s1_sem_pulso", bus.novoDado, 0);
    ciclo();
    verifica("s1_pulso", bus.novoDado, 1);
    verifica("s1_operandos", {bus.mapaX, bus.mapaY, bus.mapaDistDireita, bus.mapaDistEsquerda},
             {8'd5, 8'd7, 8'd3, 8'd2});
    verifica("s1_direcao", bus.mapaDirecao, 1);
    verifica("s1_ocupado", bus.ocupado, 1);
    verifica("s1_nivel_pop", bus.nivelFila, 0);
    bus.mapaLivre = 1'b0;
    ciclo();
    verifica("s1_pulso_unico", bus.novoDado, 0);
    repeat (9) begin
      ciclo();
      verifica("s1_estavel", {bus.mapaX, bus.mapaY}, {8'd5, 8'd7});
    end
    verifica("s1_ocupado_fim", bus.ocupado, 1);
    bus.mapaLivre = 1'b1;
    ciclo();
    verifica("s1_livre", bus.ocupado, 0);
    verifica("s1_nivel_final", bus.nivelFila, 0);
    verifica("s1_sem_erro", bus.erroTimeout, 0);

    // Overflow with depth 4
    bus.mapaLivre = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      amostra(1, 8'(i), 0, 0, 0, 0);
      ciclo();
      if (i == 4) begin
        verifica("s2_pronta_cheia", bus.amostraPronta, 0);
        verifica("s2_nivel_cheio", bus.nivelFila, 4);
      end
    end
    bus.amostraValida = 1'b0;
    verifica("s2_descartadas", bus.descartadas, 2);
    verifica("s2_nivel", bus.nivelFila, 4);
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    verifica("s2_reset_nivel", bus.nivelFila, 0);

    // Ordering: A, B, C, each answered with 3 busy cycles
    for (int i = 0; i < 3; i++) begin
      amostra(1, expX[i], expY[i], expH[i], expD[i], expE[i]);
      ciclo();
    end
    bus.amostraValida = 1'b0;
    verifica("s3_nivel", bus.nivelFila, 3);
    for (int k = 0; k < 3; k++) begin
      bus.mapaLivre = 1'b1;
      esperaEmissao("s3");
      verifica("s3_ordem", {bus.mapaX, bus.mapaY, bus.mapaDistDireita, bus.mapaDistEsquerda},
               {expX[k], expY[k], expD[k], expE[k]});
      verifica("s3_direcao", bus.mapaDirecao, expH[k]);
      bus.mapaLivre = 1'b0;
      repeat (3) begin
        ciclo();
        verifica("s3_estavel", {bus.mapaX, bus.mapaY, bus.mapaDistDireita, bus.mapaDistEsquerda},
                 {expX[k], expY[k], expD[k], expE[k]});
      end
    end
    bus.mapaLivre = 1'b1;
    ciclo();
    verifica("s3_ocioso", bus.ocupado, 0);
    verifica("s3_vazia", bus.nivelFila, 0);

    // Watchdog with mapaLivre stuck at 1
    bus.mapaLivre = 1'b0;
    amostra(1, 40, 41, 1, 42, 43);
    ciclo();
    amostra(1, 50, 51, 0, 52, 53);
    ciclo();
    bus.amostraValida = 1'b0;
    bus.mapaLivre     = 1'b1;
    ciclo();
    verifica("s4_emite_x", bus.novoDado, 1);
    verifica("s4_x", bus.mapaX, 40);
    repeat (15) ciclo();
    verifica("s4_antes_erro", bus.erroTimeout, 0);
    verifica("s4_antes_ocupado", bus.ocupado, 1);
    ciclo();
    verifica("s4_erro", bus.erroTimeout, 1);
    verifica("s4_ocioso", bus.ocupado, 0);
    ciclo();
    verifica("s4_emite_y", bus.novoDado, 1);
    verifica("s4_y", bus.mapaX, 50);
    verifica("s4_erro_fixo", bus.erroTimeout, 1);

    // Asynchronous reset in AGUARDA_FIM with 2 samples queued
    bus.mapaLivre = 1'b0;
    amostra(1, 60, 61, 1, 62, 63);
    ciclo();
    amostra(1, 70, 71, 1, 72, 73);
    ciclo();
    bus.amostraValida = 1'b0;
    verifica("s5_nivel", bus.nivelFila, 2);
    verifica("s5_ocupado", bus.ocupado, 1);
    #2 reset = 1'b1;
    #1;
    confereReset("s5");
    #2 reset = 1'b0;
    bus.mapaLivre = 1'b1;
    repeat (5) begin
      ciclo();
      verifica("s5_sem_pulso", bus.novoDado, 0);
    end
    amostra(1, 80, 81, 0, 82, 83);
    ciclo();
    bus.amostraValida = 1'b0;
    ciclo();
    verifica("s5_nova_emissao", bus.novoDado, 1);
    verifica("s5_nova_x", bus.mapaX, 80);

    // Saturation of the refused-sample counter
    reset = 1'b1;
    ciclo();
    reset         = 1'b0;
    bus.mapaLivre = 1'b0;
    amostra(1, 1, 1, 0, 1, 1);
    repeat (4 + 254) ciclo();
    verifica("s6_descartadas_254", bus.descartadas, 254);
    repeat (46) ciclo();
    verifica("s6_saturado", bus.descartadas, 255);
    bus.amostraValida = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFalhas);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulacao excedeu o limite de tempo");
    $fatal(1, "limite de tempo");
  end
endmodule
`default_nettype wire
